// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
// Multi-digit common-anode 7-segment scan controller.
//   - Picks one of NSRC hex sources.
//   - Snapshots that source once per frame, so a scan never mixes two values.
//   - Scans DIGITS digits, one slot of DIV clk cycles per digit.
//   - Blanks all anodes for the first BLANK cycles of every slot to suppress
//     ghosting.
//
// Optional build macro: SEG_DIM_EN
//   - Adds the 4-bit bright_i input and a free-running 4-bit PWM counter.
//   - The anode is on only while pwm <= bright_i.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   src_data_i    NSRC sources packed; source k at [k*4*DIGITS +: 4*DIGITS]
//   sel_i         source select; codes >= NSRC select source 0
//   dp_in_i       decimal point request per digit (1 = lit)
//   freeze_i      1 = keep the current snapshot at the frame boundary
//   bright_i      (SEG_DIM_EN only) anode PWM brightness, 15 = full on
//   seg_o         segments gfedcba, active-low, seg_o[0] = a
//   dp_o          decimal point, active-low
//   an_o          anode enables, active-low, at most one bit low
//   frame_tick_o  one-cycle pulse on the first cycle of the digit 0 slot
// -----------------------------------------------------------------------------
module seg7_scan_mux #(
  parameter int DIGITS = 8,
  parameter int NSRC   = 4,
  parameter int DIV    = 100000,
  parameter int BLANK  = 4,
  localparam int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC*4*DIGITS-1:0] src_data_i,
  input  logic [SELW-1:0]          sel_i,
  input  logic [DIGITS-1:0]        dp_in_i,
  input  logic                     freeze_i,
`ifdef SEG_DIM_EN
  input  logic [3:0]               bright_i,
`endif
  output logic [6:0]               seg_o,
  output logic                     dp_o,
  output logic [DIGITS-1:0]        an_o,
  output logic                     frame_tick_o
);

  localparam int SW   = 4 * DIGITS;
  localparam int PCW  = $clog2(DIV);
  localparam int IDXW = $clog2(DIGITS);

  logic [PCW-1:0]    pcnt_q, pcnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [SW-1:0]     snap_q;
  logic [DIGITS-1:0] dpsnap_q;
  logic              load_pending_q;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_tick_q;

  logic              slot_end, last_digit, wrap, load_snap;
  logic              in_blank, an_lit;
  logic [SW-1:0]     src_sel;
  logic [3:0]        cur_nib;
  logic              cur_dp;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Source select; any code with no matching source falls back to source 0.
  always_comb begin
    src_sel = src_data_i[SW-1:0];
    for (int k = 1; k < NSRC; k++) begin
      if (sel_i == SELW'(k)) src_sel = src_data_i[k*SW +: SW];
    end
  end

  // Slot / digit sequencing.
  assign slot_end   = (pcnt_q == PCW'(DIV - 1));
  assign last_digit = (idx_q == IDXW'(DIGITS - 1));
  assign wrap       = slot_end & last_digit;
  assign pcnt_d     = slot_end ? '0 : pcnt_q + 1'b1;
  assign idx_d      = !slot_end ? idx_q : (last_digit ? '0 : idx_q + 1'b1);

  // The first cycle out of reset loads regardless of freeze so the display
  // is valid from the first slot instead of after a whole frame.
  assign load_snap  = load_pending_q | (wrap & ~freeze_i);

  generate
    if (BLANK > 0) begin : g_blank
      assign in_blank = (pcnt_q < PCW'(BLANK));
    end else begin : g_no_blank
      assign in_blank = 1'b0;
    end
  endgenerate

`ifdef SEG_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge clk) begin
    if (reset) pwm_q <= '0;
    else       pwm_q <= pwm_q + 4'd1;
  end

  // PWM gates only the anode; segments and dp keep their value.
  assign an_lit = ~in_blank & (pwm_q <= bright_i);
`else
  assign an_lit = ~in_blank;
`endif

  // Current digit's nibble and decimal point from the snapshot.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx_q == IDXW'(d)) begin
        cur_nib = snap_q[d*4 +: 4];
        cur_dp  = dpsnap_q[d];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_an
      assign an_d[gi] = ~(an_lit & (idx_q == IDXW'(gi)));
    end
  endgenerate

  assign seg_d = in_blank ? 7'b1111111 : hex7(cur_nib);
  assign dp_d  = in_blank ? 1'b1 : ~cur_dp;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q         <= '0;
      idx_q          <= '0;
      snap_q         <= '0;
      dpsnap_q       <= '0;
      load_pending_q <= 1'b1;
      seg_q          <= 7'b1111111;
      dp_q           <= 1'b1;
      an_q           <= '1;
      frame_tick_q   <= 1'b0;
    end else begin
      pcnt_q         <= pcnt_d;
      idx_q          <= idx_d;
      load_pending_q <= 1'b0;
      if (load_snap) begin
        snap_q   <= src_sel;
        dpsnap_q <= dp_in_i;
      end
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= wrap;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_mux
// Self-checking bench for seg7_scan_mux (DIGITS=4, DIV=8, BLANK=2).
// The reference model derives the expected display from the number of clock
// edges since reset release: slot position, digit and frame boundaries follow
// from plain division/modulo, and a model snapshot is reloaded at those
// boundaries. NSRC=3 so that the 2-bit select has an out-of-range code (3).
// -----------------------------------------------------------------------------
module tb_seg7_scan_mux;

  localparam int DIGITS = 4;
  localparam int NSRC   = 3;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIV * DIGITS;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NSRC*16-1:0]   src_data;
  logic [1:0]           sel;
  logic [DIGITS-1:0]    dp_in;
  logic                 freeze;
  logic [3:0]           bright;
  logic [6:0]           seg;
  logic                 dp;
  logic [DIGITS-1:0]    an;
  logic                 frame_tick;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .DIGITS(DIGITS), .NSRC(NSRC), .DIV(DIV), .BLANK(BLANK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_data_i   (src_data),
    .sel_i        (sel),
    .dp_in_i      (dp_in),
    .freeze_i     (freeze),
`ifdef SEG_DIM_EN
    .bright_i     (bright),
`endif
    .seg_o        (seg),
    .dp_o         (dp),
    .an_o         (an),
    .frame_tick_o (frame_tick)
  );

  // Segment patterns (active-low gfedcba) for hex digits 0..F.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          checks = 0;
  int          errors = 0;
  int unsigned k = 0;       // edges since reset release
  logic [15:0] snap_m = '0;
  logic [3:0]  dps_m  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // One clock: predict outputs for the coming edge, advance, then compare.
  task automatic step();
    logic [DIGITS-1:0] e_an;
    logic [6:0]        e_seg;
    logic              e_dp, e_ft, blank, lit;
    int                p, d, s;
    if (reset) begin
      e_an = '1; e_seg = 7'b1111111; e_dp = 1'b1; e_ft = 1'b0;
      snap_m = '0; dps_m = '0; k = 0;
    end else begin
      p     = int'(k % DIV);
      d     = int'((k / DIV) % DIGITS);
      blank = (p < BLANK);
      lit   = !blank;
`ifdef SEG_DIM_EN
      lit   = lit && ((k % 16) <= bright);
`endif
      e_an  = lit ? ~(DIGITS'(1) << d) : '1;
      e_seg = blank ? 7'b1111111 : seg_tab[(snap_m >> (4*d)) & 16'hF];
      e_dp  = blank ? 1'b1 : ~dps_m[d];
      e_ft  = ((k % FRAME) == FRAME - 1);
      if (k == 0 || (e_ft && !freeze)) begin
        s      = (sel < NSRC) ? int'(sel) : 0;
        snap_m = src_data[s*16 +: 16];
        dps_m  = dp_in;
      end
      k++;
    end
    @(posedge clk);
    #1;
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the next edge index has the given position in the frame.
  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) step();
  endtask

  initial begin
    reset    = 1'b1;
    src_data = {16'h0000, 16'hBEEF, 16'h1A2F};
    sel      = 2'd0;
    dp_in    = '0;
    freeze   = 1'b0;
    bright   = 4'd15;

    $display("txn reset: hold 3 cycles");
    run(3);

    $display("txn release: src0=1A2F, 2 frames");
    reset = 1'b0;
    run(3);
    check_eq("first_lit_seg", 32'(seg), 32'(7'b0001110));
    check_eq("first_lit_an", 32'(an), 32'(4'b1110));
    run(2 * FRAME);

    $display("txn tear-free: 1234 -> 5678 mid-frame");
    src_data[15:0] = 16'h1234;
    run_to(0);
    run_to(2 * DIV + 1);
    src_data[15:0] = 16'h5678;
    run(2 * FRAME);

    $display("txn freeze: sel=1 while frozen, then release");
    freeze = 1'b1;
    sel    = 2'd1;
    run(2 * FRAME);
    freeze = 1'b0;
    run(2 * FRAME);
    $display("txn select: out-of-range sel=3");
    sel = 2'd3;
    run(2 * FRAME);

    $display("txn dp: dp_in=0100");
    dp_in = 4'b0100;
    run(2 * FRAME);

    $display("txn mid-frame reset at digit 3");
    run_to(3 * DIV + 3);
    reset = 1'b1;
    run(1);
    check_eq("midreset_an", 32'(an), 32'(4'b1111));
    reset = 1'b0;
    run(FRAME + 4);

`ifdef SEG_DIM_EN
    $display("txn dim: bright 3, 15, 0");
    bright = 4'd3;  run(2 * FRAME);
    bright = 4'd15; run(2 * FRAME);
    bright = 4'd0;  run(2 * FRAME);
`endif

    $display("txn random: 800 cycles");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) src_data = {$urandom, $urandom};
      if ($urandom_range(0, 31) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) dp_in = DIGITS'($urandom);
      if ($urandom_range(0, 63) == 0) freeze = ~freeze;
      if ($urandom_range(0, 15) == 0) bright = 4'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    run(FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
